detector_jogada: RTL and testbench

Input conditioning stage that sits directly upstream of the game datapath. It takes the raw player switches, synchronises and debounces them, and checks that exactly one key is pressed. It then delivers a registered 4-bit play code with a one-cycle `jogada_valida` strobe, which replaces the raw `chaves` / `jogada_feita` path into the datapath and control unit. It also forces a full key release before the next play can be accepted.

---
 rtl/detector_jogada_pkg.sv | 8 +
 rtl/detector_jogada_if.sv | 8 +
 rtl/detector_jogada_sincronizador.sv | 12 +
 rtl/detector_jogada.sv | 66 ++++++
 tb/tb_detector_jogada.sv | 121 ++++++++++++
 5 files changed

// File: rtl/detector_jogada_pkg.sv
// detector_pkg: shared state codes, default debounce length and one-hot check
package detector_pkg;
  typedef enum logic [3:0] {ESPERA = 4'h0, ESTABILIZA = 4'h1, SOLTAR = 4'h2} estado_t;
  localparam int N_DEBOUNCE_DEF = 50;
  function automatic logic one_hot(input logic [31:0] v);
    return v != 32'd0 && (v & (v - 32'd1)) == 32'd0;
  endfunction
endpackage

// File: rtl/detector_jogada_if.sv
// detector_jogada_if: switch inputs and conditioned play outputs of the detector
interface detector_jogada_if #(parameter int WIDTH = 4);
  logic [WIDTH-1:0] chaves, jogada;
  logic habilita, jogada_valida, erro_multipla;
  logic [3:0] db_estado;
  modport master(output chaves, habilita, input jogada, jogada_valida, erro_multipla, db_estado);
  modport slave(input chaves, habilita, output jogada, jogada_valida, erro_multipla, db_estado);
endinterface

// File: rtl/detector_jogada_sincronizador.sv
// sincronizador: two-flop synchroniser for the raw asynchronous switches
module sincronizador #(parameter int WIDTH = 4) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] meta;
  always_ff @(posedge clock or negedge reset)
    if (!reset) {q, meta} <= '0;
    else {q, meta} <= {meta, d};
endmodule

// File: rtl/detector_jogada.sv
// detector_jogada: debounces player keys, accepts one one-hot play per press/release
module detector_jogada
  import detector_pkg::*;
#(
  parameter int N_DEBOUNCE = N_DEBOUNCE_DEF,
  parameter int WIDTH = 4
) (
  input logic clock,
  input logic reset,
  detector_jogada_if.slave bus
);
  localparam int CW = N_DEBOUNCE > 1 ? $clog2(N_DEBOUNCE) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(N_DEBOUNCE - 1);
  estado_t estado;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] s, cand;
  sincronizador #(.WIDTH(WIDTH)) u_sinc (.clock(clock), .reset(reset), .d(bus.chaves), .q(s));
  assign bus.db_estado = estado;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      estado <= ESPERA;
      cnt <= '0;
      cand <= '0;
      bus.jogada <= '0;
      bus.jogada_valida <= 1'b0;
      bus.erro_multipla <= 1'b0;
    end else begin
      bus.jogada_valida <= 1'b0;
      bus.erro_multipla <= 1'b0;
      case (estado)
        ESPERA: begin
          cnt <= '0;
          if (s != '0) begin
            estado <= bus.habilita ? ESTABILIZA : SOLTAR;
            if (bus.habilita) cand <= s;
          end
        end
        ESTABILIZA:
          if (s != cand) begin
            estado <= ESPERA;
            cnt <= '0;
          end else if (!bus.habilita) begin
            estado <= SOLTAR;
            cnt <= '0;
          end else if (cnt == CNT_MAX) begin
            estado <= SOLTAR;
            cnt <= '0;
            if (one_hot(32'(cand))) begin
              bus.jogada <= cand;
              bus.jogada_valida <= 1'b1;
            end else bus.erro_multipla <= 1'b1;
          end else cnt <= cnt + 1'b1;
        SOLTAR:
          // any key still down restarts the release window
          if (s != '0) cnt <= '0;
          else if (cnt == CNT_MAX) begin
            estado <= ESPERA;
            cnt <= '0;
          end else cnt <= cnt + 1'b1;
        default: begin
          estado <= ESPERA;
          cnt <= '0;
        end
      endcase
    end
endmodule

// File: tb/tb_detector_jogada.sv
// tb_detector_jogada: randomized press episodes scored against a rule-level model
module tb_detector_jogada;
  import detector_pkg::*;
  localparam int N = 4;
  localparam int LAT = N + 3;
  logic clock = 1'b0;
  logic reset = 1'b0;
  detector_jogada_if #(.WIDTH(4)) bus();
  detector_jogada #(.N_DEBOUNCE(N), .WIDTH(4)) dut (.clock(clock), .reset(reset), .bus(bus));
  always #5 clock = ~clock;
  typedef struct {logic err; logic [3:0] code; int cyc;} exp_t;
  exp_t sb[$];
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  logic [3:0] model_jogada = 4'd0;
  always @(posedge clock) cyc <= cyc + 1;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask
  always @(negedge clock)
    if (reset) begin
      exp_t e;
      check("exclusive_pulses", 32'(bus.jogada_valida & bus.erro_multipla), 32'd0);
      if (bus.jogada_valida | bus.erro_multipla) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_pulse: got valida=%b erro=%b expected no pulse at cycle %0d",
                   bus.jogada_valida, bus.erro_multipla, cyc);
        end else begin
          e = sb.pop_front();
          check("pulse_is_error", 32'(bus.erro_multipla), 32'(e.err));
          check("pulse_cycle", cyc, e.cyc);
          if (!e.err) model_jogada = e.code;
        end
      end
      check("jogada_held", 32'(bus.jogada), 32'(model_jogada));
    end
  task automatic drive(input logic [3:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      bus.chaves = v;
    end
  endtask
  // en=0: habilita low at the press and raised while the key is still held
  task automatic episode(input logic [3:0] v, input bit en, input int bounces, input int hold);
    int k;
    bus.habilita = en;
    for (int b = 0; b < bounces; b++) begin
      drive(v, $urandom_range(1, 2));
      drive(4'd0, $urandom_range(1, 2));
    end
    @(negedge clock);
    bus.chaves = v;
    k = cyc;
    if (en && v != 4'd0) sb.push_back('{err: $countones(v) != 1, code: v, cyc: k + LAT});
    for (int i = 1; i < hold; i++) begin
      @(negedge clock);
      if (i == 3) bus.habilita = 1'b1;
    end
    drive(4'd0, N + 6);
    check("idle_after_release", 32'(bus.db_estado), 32'(ESPERA));
  endtask
  initial begin
    #1_000_000;
    $display("FAIL timeout: got no end of test expected finish by 1000000");
    $fatal(1);
  end
  initial begin
    int k;
    bus.chaves = 4'd0;
    bus.habilita = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      bus.chaves = i[0] ? 4'b0100 : 4'b0000;
      check("rst_jogada", 32'(bus.jogada), 32'd0);
      check("rst_valida", 32'(bus.jogada_valida), 32'd0);
      check("rst_erro", 32'(bus.erro_multipla), 32'd0);
      check("rst_estado", 32'(bus.db_estado), 32'd0);
    end
    @(negedge clock);
    bus.chaves = 4'd0;
    #2 reset = 1'b1;
    drive(4'd0, 5);
    check("idle_after_reset", 32'(bus.db_estado), 32'(ESPERA));
    episode(4'b0010, 1'b1, 0, 58);
    episode(4'b0010, 1'b1, 5, 12);
    episode(4'b0110, 1'b1, 0, 12);
    episode(4'b1000, 1'b1, 0, 10);
    episode(4'b0001, 1'b0, 0, 12);
    episode(4'b0001, 1'b1, 0, 10);
    for (int r = 0; r < 40; r++)
      episode(4'($urandom_range(1, 15)), 1'($urandom_range(0, 1)), $urandom_range(0, 4),
              $urandom_range(8, 60));
    bus.habilita = 1'b1;
    @(negedge clock);
    bus.chaves = 4'b0100;
    k = cyc;
    while (cyc < k + 5) @(negedge clock);
    check("mid_debounce_state", 32'(bus.db_estado), 32'(ESTABILIZA));
    #1 reset = 1'b0;
    model_jogada = 4'd0;
    #1;
    check("async_rst_estado", 32'(bus.db_estado), 32'd0);
    check("async_rst_jogada", 32'(bus.jogada), 32'd0);
    check("async_rst_valida", 32'(bus.jogada_valida), 32'd0);
    drive(4'b0100, 4);
    @(negedge clock);
    bus.chaves = 4'd0;
    #2 reset = 1'b1;
    drive(4'd0, 20);
    check("scoreboard_drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
